// File: rtl/ads_frame_mem_writer.sv
// Packs ADS1299 sample beats into header+data frames and writes them as 32-bit
// words into a circular frame buffer through an Avalon-MM write master.
module ads_frame_mem_writer #(
    parameter int NUM_CH       = 8,
    parameter int ADDR_W       = 15,
    parameter int BASE_WORD    = 0,
    parameter int BUF_FRAMES   = 3640,
    parameter int BLOCK_FRAMES = 250
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              s_valid,
    input  logic              s_sop,
    input  logic [23:0]       s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    input  logic              m_waitrequest,
    output logic [ADDR_W-1:0] frame_slot,
    output logic [15:0]       seq,
    output logic              frame_done,
    output logic              block_irq,
    output logic              frame_err,
    output logic [1:0]        dbg_state_o
);

    localparam int CH_W  = $clog2(NUM_CH + 1);
    localparam int BLK_W = $clog2(BLOCK_FRAMES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [CH_W-1:0]   LAST_CH      = CH_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] BASE_A       = ADDR_W'(BASE_WORD);
    localparam logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(NUM_CH + 1);
    localparam logic [ADDR_W-1:0] LAST_SLOT    = ADDR_W'(BUF_FRAMES - 1);
    localparam logic [BLK_W-1:0]  LAST_BLK     = BLK_W'(BLOCK_FRAMES - 1);
    localparam logic [3:0]        NCH4         = 4'(NUM_CH);

    logic [1:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0] fbase_q, fbase_d;
    logic [ADDR_W-1:0] slot_q, slot_d;
    logic [15:0]       seq_q, seq_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              irq_q, irq_d;
    logic              err_q, err_d;

    logic        bus_free;
    logic        beat_acc;
    logic        trunc;
    logic [31:0] hdr_word;
    logic [31:0] smp_word;

    // Handshakes: a sample beat transfers on a rising edge where s_valid and
    // s_ready are both high; a bus write is taken on a rising edge where
    // m_write is high and m_waitrequest is low, otherwise m_* hold.
    assign bus_free = ~wr_q | ~m_waitrequest;
    assign hdr_word = {8'hA5, 4'h0, NCH4, seq_q};
    assign smp_word = {{8{s_data[23]}}, s_data};
    assign trunc    = (state_q == S_DATA) && s_valid && s_sop &&
                      (ch_q != '0) && (ch_q != LAST_CH);

    always_comb begin
        s_ready = 1'b0;
        if (reset_n) begin
            case (state_q)
                S_IDLE:  s_ready = ~s_sop;
                S_HDR:   s_ready = bus_free;
                S_DATA:  s_ready = bus_free && (ch_q != LAST_CH) && !(s_sop && (ch_q != '0));
                default: s_ready = 1'b0;
            endcase
        end
    end

    assign beat_acc = s_valid & s_ready;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        fbase_d = fbase_q;
        slot_d  = slot_q;
        seq_d   = seq_q;
        blk_d   = blk_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        irq_d   = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                // The sop beat stays on the stream; it becomes channel 0 in HDR.
                if (enable && s_valid && s_sop) begin
                    state_d = S_HDR;
                    ch_d    = '0;
                    wr_d    = 1'b1;
                    addr_d  = fbase_q;
                    wdata_d = hdr_word;
                end
            end
            S_HDR, S_DATA: begin
                if (bus_free) begin
                    state_d = S_DATA;
                    if ((state_q == S_DATA) && (ch_q == LAST_CH)) begin
                        state_d = S_IDLE;
                        wr_d    = 1'b0;
                        ch_d    = '0;
                        done_d  = 1'b1;
                        seq_d   = seq_q + 16'd1;
                        if (slot_q == LAST_SLOT) begin
                            slot_d  = '0;
                            fbase_d = BASE_A;
                        end else begin
                            slot_d  = slot_q + ADDR_W'(1);
                            fbase_d = fbase_q + FRAME_STRIDE;
                        end
                        if (blk_q == LAST_BLK) begin
                            irq_d = 1'b1;
                            blk_d = '0;
                        end else begin
                            blk_d = blk_q + BLK_W'(1);
                        end
                    end else if (trunc) begin
                        // Early sop: restart the same slot and seq over the partial frame.
                        state_d = S_HDR;
                        err_d   = 1'b1;
                        ch_d    = '0;
                        wr_d    = 1'b1;
                        addr_d  = fbase_q;
                        wdata_d = hdr_word;
                    end else if (beat_acc) begin
                        wr_d    = 1'b1;
                        addr_d  = fbase_q + ADDR_W'(ch_q) + ADDR_W'(1);
                        wdata_d = smp_word;
                        ch_d    = ch_q + CH_W'(1);
                    end else begin
                        wr_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            fbase_q <= BASE_A;
            slot_q  <= '0;
            seq_q   <= '0;
            blk_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= BASE_A;
            wdata_q <= '0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            fbase_q <= fbase_d;
            slot_q  <= slot_d;
            seq_q   <= seq_d;
            blk_q   <= blk_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
        end
    end

    assign m_address    = addr_q;
    assign m_byteenable = 4'hF;
    assign m_chipselect = wr_q;
    assign m_write      = wr_q;
    assign m_writedata  = wdata_q;
    assign frame_slot   = slot_q;
    assign seq          = seq_q;
    assign frame_done   = done_q;
    assign block_irq    = irq_q;
    assign frame_err    = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ads_frame_mem_writer.sv
// Directed bench for ads_frame_mem_writer: frame-level model of expected RAM
// writes and frame completions, checked every cycle against the bus.
module tb_ads_frame_mem_writer;

    localparam int NUM_CH       = 8;
    localparam int ADDR_W       = 15;
    localparam int BASE_WORD    = 0;
    localparam int BUF_FRAMES   = 3640;
    localparam int BLOCK_FRAMES = 250;

    logic              clk;
    logic              reset_n;
    logic              enable;
    logic              s_valid;
    logic              s_sop;
    logic [23:0]       s_data;
    logic              s_ready;
    logic [ADDR_W-1:0] m_address;
    logic [3:0]        m_byteenable;
    logic              m_chipselect;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic              m_waitrequest;
    logic [ADDR_W-1:0] frame_slot;
    logic [15:0]       seq;
    logic              frame_done;
    logic              block_irq;
    logic              frame_err;
    logic [1:0]        dbg_state;

    ads_frame_mem_writer #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BASE_WORD(BASE_WORD),
        .BUF_FRAMES(BUF_FRAMES), .BLOCK_FRAMES(BLOCK_FRAMES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .s_valid(s_valid), .s_sop(s_sop), .s_data(s_data), .s_ready(s_ready),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect), .m_write(m_write),
        .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
        .frame_slot(frame_slot), .seq(seq), .frame_done(frame_done),
        .block_irq(block_irq), .frame_err(frame_err), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters and model ----------------
    int n_checks = 0;
    int n_errors = 0;
    int irq_cnt  = 0;
    int done_cnt = 0;
    bit mon_en   = 1'b0;
    bit prev_stall = 1'b0;

    int m_seq    = 0;
    int m_slot   = 0;
    int m_frames = 0;
    bit m_err    = 1'b0;

    logic [63:0] exp_q[$];   // {address, data} of each expected bus write
    logic [33:0] done_q[$];  // {seq, slot, irq, err} at each frame completion
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [23:0] fdata [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] hdr_word(input int s);
        return {8'hA5, 4'h0, 4'(NUM_CH), 16'(s)};
    endfunction

    function automatic logic [31:0] slot_base(input int sl);
        return 32'(BASE_WORD + sl * (NUM_CH + 1));
    endfunction

    function automatic logic [31:0] sext(input logic [23:0] d);
        return 32'($signed(d));
    endfunction

    function automatic logic [23:0] pat(input int f, input int c);
        logic [23:0] v;
        v = 24'(f * 131 + c * 7919 + 5);
        if (c % 3 == 0) v[23] = ~v[23];
        return v;
    endfunction

    task automatic fill(input int f);
        for (int c = 0; c < NUM_CH; c++) fdata[c] = pat(f, c);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic sop, input logic [23:0] d);
        bit got;
        bit acc;
        got = 1'b0;
        s_valid = 1'b1;
        s_sop   = sop;
        s_data  = d;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) got = 1'b1;
        end
        s_valid = 1'b0;
        s_sop   = 1'b0;
        check("beat_accept", 32'(got), 32'd1);
    endtask

    task automatic send_partial(input int n);
        exp_q.push_back({slot_base(m_slot), hdr_word(m_seq)});
        for (int c = 0; c < n; c++) begin
            exp_q.push_back({slot_base(m_slot) + 32'(c + 1), sext(fdata[c])});
            send_beat(c == 0, fdata[c]);
        end
    endtask

    task automatic send_frame();
        send_partial(NUM_CH);
        m_seq    = (m_seq + 1) % 65536;
        m_slot   = (m_slot + 1) % BUF_FRAMES;
        m_frames = m_frames + 1;
        done_q.push_back({16'(m_seq), 16'(m_slot), (m_frames % BLOCK_FRAMES) == 0, m_err});
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #2;
        check("drain", 32'(exp_q.size() + done_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            logic [63:0] e;
            logic [33:0] d;
            check("byteenable", 32'(m_byteenable), 32'hF);
            check("chipselect", 32'(m_chipselect), 32'(m_write));
            if (prev_stall) check("hold_write", 32'(m_write), 32'd1);
            if (m_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(m_address), 32'hFFFFFFFF);
                end else begin
                    e = exp_q[0];
                    check("wr_addr", 32'(m_address), e[63:32]);
                    check("wr_data", m_writedata, e[31:0]);
                    if (!m_waitrequest) begin
                        void'(exp_q.pop_front());
                        mem[m_address] = m_writedata;
                    end
                end
                if (m_waitrequest) check("stall_ready", 32'(s_ready), 32'd0);
            end
            prev_stall = m_write && m_waitrequest;
            if (frame_done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'(seq), 32'hFFFFFFFF);
                end else begin
                    d = done_q.pop_front();
                    check("done_seq", 32'(seq), 32'(d[33:18]));
                    check("done_slot", 32'(frame_slot), 32'(d[17:2]));
                    check("done_irq", 32'(block_irq), 32'(d[1]));
                    check("done_err", 32'(frame_err), 32'(d[0]));
                end
            end else begin
                check("irq_without_done", 32'(block_irq), 32'd0);
            end
            if (block_irq) irq_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        s_valid       = 1'b0;
        s_sop         = 1'b0;
        s_data        = '0;
        m_waitrequest = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_write", 32'(m_write), 32'd0);
        check("rst_chipselect", 32'(m_chipselect), 32'd0);
        check("rst_m_address", 32'(m_address), 32'(BASE_WORD));
        check("rst_m_writedata", m_writedata, 32'd0);
        check("rst_frame_slot", 32'(frame_slot), 32'd0);
        check("rst_seq", 32'(seq), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_block_irq", 32'(block_irq), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;
        mon_en  = 1'b1;

        // Stray non-sop beats in IDLE are dropped without any write.
        send_beat(1'b0, 24'h123456);
        send_beat(1'b0, 24'h654321);

        // Frame 0: samples 1..8.
        for (int c = 0; c < NUM_CH; c++) fdata[c] = 24'(c + 1);
        send_frame();
        wait_drain();
        check("f0_hdr", mem[0], 32'hA5080000);
        check("f0_ch0", mem[1], 32'h00000001);
        check("f0_ch7", mem[8], 32'h00000008);
        check("f0_seq", 32'(seq), 32'd1);
        check("f0_slot", 32'(frame_slot), 32'd1);
        check("f0_done_cnt", 32'(done_cnt), 32'd1);

        // Frame 1: sign-extension extremes.
        fill(1);
        fdata[0] = 24'h800000;
        fdata[1] = 24'h7FFFFF;
        send_frame();
        wait_drain();
        check("f1_hdr", mem[9], 32'hA5080001);
        check("f1_neg", mem[10], 32'hFF800000);
        check("f1_pos", mem[11], 32'h007FFFFF);

        // Truncated frame: sop arrives at channel 3, slot 2 is rewritten.
        fill(2);
        send_partial(3);
        m_err = 1'b1;
        fill(102);
        send_frame();
        wait_drain();
        check("trunc_err", 32'(frame_err), 32'd1);
        check("trunc_hdr", mem[18], 32'hA5080002);
        check("trunc_ch0", mem[19], sext(pat(102, 0)));
        check("trunc_seq", 32'(seq), 32'd3);
        check("trunc_slot", 32'(frame_slot), 32'd3);

        // Five stalled cycles mid-frame.
        fill(3);
        fork
            send_frame();
            begin
                repeat (4) @(posedge clk);
                #1 m_waitrequest = 1'b1;
                repeat (5) @(posedge clk);
                #1 m_waitrequest = 1'b0;
            end
        join
        wait_drain();
        check("stall_seq", 32'(seq), 32'd4);
        check("stall_hdr", mem[27], 32'hA5080003);

        // Stream to 500 frames since reset: two block interrupts.
        for (int f = 4; f < 500; f++) begin
            fill(f);
            send_frame();
        end
        wait_drain();
        check("irq_500", 32'(irq_cnt), 32'd2);

        // Stream through the wrap: frame 3640 lands at slot 0.
        for (int f = 500; f <= 3640; f++) begin
            fill(f);
            send_frame();
        end
        wait_drain();
        check("wrap_hdr", mem[0], 32'hA5080E38);
        check("wrap_slot", 32'(frame_slot), 32'd1);
        check("wrap_seq", 32'(seq), 32'd3641);
        check("wrap_irq", 32'(irq_cnt), 32'd14);

        // One-cycle reset in the middle of a frame.
        fill(7);
        send_partial(2);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        m_seq    = 0;
        m_slot   = 0;
        m_frames = 0;
        m_err    = 1'b0;
        @(negedge clk);
        check("mrst_m_write", 32'(m_write), 32'd0);
        check("mrst_seq", 32'(seq), 32'd0);
        check("mrst_slot", 32'(frame_slot), 32'd0);
        check("mrst_err", 32'(frame_err), 32'd0);
        check("mrst_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        fill(8);
        send_frame();
        wait_drain();
        check("mrst_hdr", mem[BASE_WORD], 32'hA5080000);
        check("mrst_seq_after", 32'(seq), 32'd1);
        check("mrst_slot_after", 32'(frame_slot), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
